// File: rtl/jt7759_phrase_seq.sv
`default_nettype none
// ============================================================================
// Module   : jt7759_phrase_seq
// Purpose  : Queues host phrase numbers and plays them back-to-back on a
//            jt7759 in stand-alone mode: present din, pulse stn, then wait
//            for busyn to fall and rise again before the next phrase.
// Ports    : clk, rstn (async, active low), cen (640 kHz enable)
//            cmd_we/cmd_din/flush           host side
//            cmd_full/cmd_empty/ovf/tmo_err status (ovf, tmo_err sticky)
//            playing/cur_phr/done           sequencer status
//            stn/din/busyn                  jt7759 side
// Revision : 1.0 - initial release
// ============================================================================
module jt7759_phrase_seq #(
  parameter int DEPTH = 8,   // power of two, 2..64
  parameter int STW   = 2,   // stn low width in cen ticks, 1..15
  parameter int GAP   = 4,   // idle cen ticks between phrases, 0..255
  parameter int TMO   = 64   // cen ticks allowed for busyn to fall, 1..255
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cen,
  input  logic       cmd_we,
  input  logic [7:0] cmd_din,
  input  logic       flush,
  output logic       cmd_full,
  output logic       cmd_empty,
  output logic       ovf,
  output logic       tmo_err,
  output logic       playing,
  output logic [7:0] cur_phr,
  output logic       done,
  output logic       stn,
  output logic [7:0] din,
  input  logic       busyn
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    WAITB = 3'd3,
    PLAY  = 3'd4,
    GAPW  = 3'd5
  } state_t;

  state_t        state, state_nx;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [7:0]    cnt, cnt_nx;
  logic          push, pop;
  logic          stn_nx, done_nx, tmo_set;

  assign cmd_full  = (count == FULL_CNT);
  assign cmd_empty = (count == '0);
  assign playing   = (state != IDLE);

  // flush wins over a same-cycle write; the write is silently dropped
  assign push = cmd_we && !cmd_full && !flush;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stn_nx   = stn;
    done_nx  = 1'b0;
    tmo_set  = 1'b0;
    pop      = 1'b0;
    case (state)
      // The pop is the only step not qualified by cen, so a queued phrase
      // leaves the FIFO on the very next clk once the chip is free.
      IDLE: begin
        if (!cmd_empty && busyn && !flush) begin
          pop      = 1'b1;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        if (cen) begin
          state_nx = START;
          stn_nx   = 1'b0;
          cnt_nx   = 8'(STW - 1);
        end
      end
      START: begin
        if (cen) begin
          if (cnt == 8'd0) begin
            stn_nx   = 1'b1;
            state_nx = WAITB;
            cnt_nx   = 8'(TMO);
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
      end
      // cnt counts remaining ticks; the last allowed tick is cnt==1
      WAITB: begin
        if (cen) begin
          if (!busyn) begin
            state_nx = PLAY;
          end else if (cnt <= 8'd1) begin
            tmo_set  = 1'b1;
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
      end
      PLAY: begin
        if (cen && busyn) begin
          done_nx  = 1'b1;
          cnt_nx   = 8'(GAP);
          state_nx = GAPW;
        end
      end
      GAPW: begin
        if (cen) begin
          if (cnt == 8'd0) begin
            state_nx = IDLE;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      stn     <= 1'b1;
      done    <= 1'b0;
      din     <= 8'd0;
      cur_phr <= 8'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf     <= 1'b0;
      tmo_err <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      stn   <= stn_nx;
      done  <= done_nx;

      if (pop) begin
        din     <= mem[rd_ptr];
        cur_phr <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + AW'(1);
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end

      // flush only empties the queue; a phrase in flight keeps running
      if (flush) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else if (push && !pop) begin
        count <= count + (AW+1)'(1);
      end else if (pop && !push) begin
        count <= count - (AW+1)'(1);
      end

      if (flush) begin
        ovf <= 1'b0;
      end else if (cmd_we && cmd_full) begin
        ovf <= 1'b1;
      end

      if (flush) begin
        tmo_err <= 1'b0;
      end else if (tmo_set) begin
        tmo_err <= 1'b1;
      end
    end
  end

  // storage needs no reset: only entries between the pointers are ever read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cmd_din;
    end
  end

endmodule
`default_nettype wire
